// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One iteration per clock, one conditional-subtraction cycle, then a one-cycle done pulse.
module mont_mul_radix2 #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] n_prime,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SW    = WIDTH + 2;

  // Handshake: start is a level sampled only in IDLE; done pulses for one
  // cycle with result valid; start must be seen low before the next accept.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SUB     = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_n;
  logic [SW-1:0]      r_s;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_result;

  logic [SW-1:0]      w_t;
  logic [SW-1:0]      w_u;
  logic [SW-1:0]      w_n_ext;
  logic [SW-1:0]      w_diff;
  logic               w_ge;
  logic               w_last;
  logic               w_unused;

  // n is odd, so the radix-2 quotient digit is just t[0]; n_prime is not needed.
  assign w_unused = ^n_prime;

  assign w_n_ext = {2'b00, r_n};
  assign w_t     = r_s + (r_a_sh[0] ? {2'b00, r_b} : '0);
  assign w_u     = w_t + (w_t[0] ? w_n_ext : '0);
  assign w_ge    = (r_s >= w_n_ext);
  assign w_diff  = r_s - w_n_ext;
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = SUB;
      SUB:     w_next = DONE;
      DONE:    w_next = start ? RELEASE : IDLE;
      RELEASE: if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b      <= '0;
      r_n      <= '0;
      r_s      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b    <= b;
            r_n    <= n;
            r_s    <= '0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_s    <= w_u >> 1;
          r_a_sh <= r_a_sh >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        SUB: begin
          // S < 2n when a,b < n, so one subtraction fully reduces.
          r_result <= w_ge ? w_diff[WIDTH-1:0] : r_s[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign done      = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == SUB);
  assign dbg_state = r_state;

endmodule
